// File: rtl/time_pkg.sv
// Shared constants and helpers for the time-unit counter family.
//   SEC_MODULUS / MIN_MODULUS / HOUR_MODULUS / DAY_MODULUS : stage moduli
//   timeWidth(modulus) : smallest count width w with 2**w >= modulus
package time_pkg;

  localparam int SEC_MODULUS  = 60;
  localparam int MIN_MODULUS  = 60;
  localparam int HOUR_MODULUS = 24;
  localparam int DAY_MODULUS  = 7;

  // Minimum register width able to hold 0..modulus-1 (at least 1 bit).
  function automatic int timeWidth(input int modulus);
    int w;
    w = 1;
    while ((1 << w) < modulus) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-value logic for a modulo-N up/down counter.
// Ports:
//   count      in  WIDTH  present count (assumed < MODULUS)
//   up         in  1      1 = increment, 0 = decrement
//   nextCount  out WIDTH  value after one step, wrapping explicitly
//   atTerminal out 1      count is at the terminal value for this direction
//   wrap       out 1      the step from count wraps around
module mod_n_next #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = time_pkg::timeWidth(MODULUS)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] nextCount,
  output logic             atTerminal,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZeroVal = WIDTH'(0);
  localparam logic [WIDTH-1:0] OneVal  = WIDTH'(1);

  // Step computation; wrap is explicit so non-power-of-two moduli are exact.
  always_comb begin
    nextCount  = count;
    atTerminal = 1'b0;
    if (up) begin
      atTerminal = (count == MaxVal);
      if (atTerminal) begin
        nextCount = ZeroVal;
      end else begin
        nextCount = count + OneVal;
      end
    end else begin
      atTerminal = (count == ZeroVal);
      if (atTerminal) begin
        nextCount = MaxVal;
      end else begin
        nextCount = count - OneVal;
      end
    end
    wrap = atTerminal;
  end

endmodule

// File: rtl/mod_n_time_counter.sv
// Parametrised modulo-N time-unit counter (seconds/minutes/hours/days stage).
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   En, Up             count enable / carry-in, direction (1 = up)
//   Clear              synchronous clear to 0
//   Load, LoadValue    parallel load (out-of-range values clamp to MODULUS-1)
//   AlarmEn, AlarmValue compare-match enable and value
//   Count              current count (registered)
//   TermCount          combinational En & at-terminal, for same-edge cascading
//   CarryOut           registered pulse in the cycle Count shows a wrapped value
//   LoadError          registered pulse after an out-of-range load
//   AlarmMatch         registered AlarmEn & (Count == AlarmValue), one cycle late
// Per-edge priority: reset > Clear > Load > En.
module mod_n_time_counter
  import time_pkg::*;
#(
  parameter int MODULUS     = 60,
  parameter int WIDTH       = timeWidth(MODULUS),
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             AlarmEn,
  input  logic [WIDTH-1:0] AlarmValue,
  output logic [WIDTH-1:0] Count,
  output logic             TermCount,
  output logic             CarryOut,
  output logic             LoadError,
  output logic             AlarmMatch
);

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VALUE);
  // One extra bit so MODULUS = 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   ModExt   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_r;
  logic             carry_r;
  logic             loadErr_r;
  logic             alarm_r;

  logic [WIDTH-1:0] stepCount_s;
  logic             atTerm_s;
  logic             wrap_s;
  logic             loadInRange_s;
  logic             alarmInRange_s;
  logic [WIDTH-1:0] countNext_s;
  logic             carryNext_s;
  logic             loadErrNext_s;
  logic             alarmNext_s;

  mod_n_next #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) uNext (
    .count      (count_r),
    .up         (Up),
    .nextCount  (stepCount_s),
    .atTerminal (atTerm_s),
    .wrap       (wrap_s)
  );

  assign loadInRange_s  = ({1'b0, LoadValue}  < ModExt);
  assign alarmInRange_s = ({1'b0, AlarmValue} < ModExt);

  // Same-cycle carry into the next stage; deliberately not registered.
  assign TermCount = En & atTerm_s;

  // Priority mux Clear > Load > En; pulses default low so they last one cycle.
  always_comb begin
    countNext_s   = count_r;
    carryNext_s   = 1'b0;
    loadErrNext_s = 1'b0;
    if (Clear) begin
      countNext_s = WIDTH'(0);
    end else if (Load) begin
      if (loadInRange_s) begin
        countNext_s = LoadValue;
      end else begin
        countNext_s   = MaxVal;
        loadErrNext_s = 1'b1;
      end
    end else if (En) begin
      countNext_s = stepCount_s;
      carryNext_s = wrap_s;
    end else begin
      countNext_s = count_r;
    end
    // Compare uses the pre-edge count, giving one cycle of latency.
    alarmNext_s = AlarmEn & alarmInRange_s & (count_r == AlarmValue);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r   <= ResetVal;
      carry_r   <= 1'b0;
      loadErr_r <= 1'b0;
      alarm_r   <= 1'b0;
    end else begin
      count_r   <= countNext_s;
      carry_r   <= carryNext_s;
      loadErr_r <= loadErrNext_s;
      alarm_r   <= alarmNext_s;
    end
  end

  assign Count      = count_r;
  assign CarryOut   = carry_r;
  assign LoadError  = loadErr_r;
  assign AlarmMatch = alarm_r;

endmodule

// File: tb/tb_mod_n_time_counter.sv
// Self-checking bench for mod_n_time_counter: directed and random steps on a
// mod-60 instance against an arithmetic model, plus a seconds->minutes chain.
module tb_mod_n_time_counter;

  localparam int M = 60;

  logic       clk = 1'b0;
  logic       reset, En, Up, Clear, Load, AlarmEn;
  logic [5:0] LoadValue, AlarmValue;
  logic [5:0] Count;
  logic       TermCount, CarryOut, LoadError, AlarmMatch;

  // chain: seconds (60) feeding minutes (24, reset value 5)
  logic       cRst, cUp, cClear, cLoad, sEn;
  logic [5:0] sLv, sCount;
  logic [4:0] mLv, mCount;
  logic       sTerm, sCarry, sErr, sAl, mTerm, mCarry, mErr, mAl;

  int total = 0;
  int bad   = 0;

  // reference model state
  int mC, mCarryE, mErrE, mAlarmE;

  always #5 clk = ~clk;

  mod_n_time_counter #(.MODULUS(M)) dut (
    .clk(clk), .reset(reset), .En(En), .Up(Up), .Clear(Clear), .Load(Load),
    .LoadValue(LoadValue), .AlarmEn(AlarmEn), .AlarmValue(AlarmValue),
    .Count(Count), .TermCount(TermCount), .CarryOut(CarryOut),
    .LoadError(LoadError), .AlarmMatch(AlarmMatch)
  );

  mod_n_time_counter #(.MODULUS(60)) secStage (
    .clk(clk), .reset(cRst), .En(sEn), .Up(cUp), .Clear(cClear), .Load(cLoad),
    .LoadValue(sLv), .AlarmEn(1'b0), .AlarmValue(6'd0),
    .Count(sCount), .TermCount(sTerm), .CarryOut(sCarry),
    .LoadError(sErr), .AlarmMatch(sAl)
  );

  mod_n_time_counter #(.MODULUS(24), .RESET_VALUE(5)) minStage (
    .clk(clk), .reset(cRst), .En(sTerm), .Up(cUp), .Clear(cClear), .Load(cLoad),
    .LoadValue(mLv), .AlarmEn(1'b0), .AlarmValue(5'd0),
    .Count(mCount), .TermCount(mTerm), .CarryOut(mCarry),
    .LoadError(mErr), .AlarmMatch(mAl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of the mod-60 instance: drive, check TermCount, update model, check outputs.
  task automatic cycle(input bit rst, input bit clr, input bit ld, input int lv,
                       input bit en, input bit up, input bit aen, input int av);
    int expTerm;
    reset = rst; Clear = clr; Load = ld; LoadValue = 6'(lv);
    En = en; Up = up; AlarmEn = aen; AlarmValue = 6'(av);
    #1;
    expTerm = (en && (up ? (mC == M - 1) : (mC == 0))) ? 1 : 0;
    chk("TermCount", {31'd0, TermCount}, expTerm);
    if (rst) begin
      mC = 0; mCarryE = 0; mErrE = 0; mAlarmE = 0;
    end else begin
      mAlarmE = (aen && mC == av) ? 1 : 0;
      mCarryE = 0; mErrE = 0;
      if (clr) mC = 0;
      else if (ld) begin
        if (lv < M) mC = lv;
        else begin mC = M - 1; mErrE = 1; end
      end else if (en) begin
        mCarryE = (up ? (mC == M - 1) : (mC == 0)) ? 1 : 0;
        mC = (mC + (up ? 1 : M - 1)) % M;
      end
    end
    @(posedge clk);
    #1;
    chk("Count",      {26'd0, Count},      mC);
    chk("CarryOut",   {31'd0, CarryOut},   mCarryE);
    chk("LoadError",  {31'd0, LoadError},  mErrE);
    chk("AlarmMatch", {31'd0, AlarmMatch}, mAlarmE);
  endtask

  initial begin
    mC = 0; mCarryE = 0; mErrE = 0; mAlarmE = 0;
    cRst = 1'b1; cUp = 1'b1; cClear = 1'b0; cLoad = 1'b0; sEn = 1'b0;
    sLv = 6'd0; mLv = 5'd0;
    @(posedge clk); #1;

    // reset, then full up sweep with wrap
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 61; i++) cycle(0, 0, 0, 0, 1, 1, 0, 0);

    // load 5, count down through borrow
    cycle(0, 0, 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);

    // out-of-range load clamps, then a legal one
    cycle(0, 0, 1, 63, 0, 1, 0, 0);
    cycle(0, 0, 1, 10, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);

    // Clear beats Load and En; reset beats En
    cycle(0, 0, 1, 30, 0, 1, 0, 0);
    cycle(0, 1, 1, 7, 1, 1, 0, 0);
    cycle(0, 0, 1, 44, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 1, 0, 0);

    // alarm at 12, then an unreachable alarm value across a full sweep
    cycle(0, 0, 1, 10, 0, 1, 1, 12);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 1, 1, 12);
    for (int i = 0; i < 61; i++) cycle(0, 0, 0, 0, 1, 1, 1, 60);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 5),
            ($urandom_range(99, 0) < 10), int'($urandom_range(63, 0)),
            ($urandom_range(99, 0) < 80), ($urandom_range(99, 0) < 60),
            ($urandom_range(99, 0) < 70), int'($urandom_range(63, 0)));
    end

    // chain: reset values, load 59:23, single-edge rollover
    cRst = 1'b1; @(posedge clk); #1;
    chk("chainRstSec", {26'd0, sCount}, 0);
    chk("chainRstMin", {27'd0, mCount}, 5);
    cRst = 1'b0; cLoad = 1'b1; sLv = 6'd59; mLv = 5'd23;
    @(posedge clk); #1;
    chk("chainLdSec", {26'd0, sCount}, 59);
    chk("chainLdMin", {27'd0, mCount}, 23);
    cLoad = 1'b0; sEn = 1'b1; #1;
    chk("chainSecTerm", {31'd0, sTerm}, 1);
    chk("chainMinTerm", {31'd0, mTerm}, 1);
    @(posedge clk); #1;
    chk("chainWrapSec",  {26'd0, sCount}, 0);
    chk("chainWrapMin",  {27'd0, mCount}, 0);
    chk("chainSecCarry", {31'd0, sCarry}, 1);
    chk("chainMinCarry", {31'd0, mCarry}, 1);
    chk("chainMinTermAfter", {31'd0, mTerm}, 0);
    @(posedge clk); #1;
    chk("chainNextSec",  {26'd0, sCount}, 1);
    chk("chainHoldMin",  {27'd0, mCount}, 0);
    chk("chainMinCarryClr", {31'd0, mCarry}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
